qcl_swpo_frame: RTL and testbench

//  Addressed serial-write / parallel-out frame assembler with valid-ready handshakes.

---
 rtl/qcl_pkg.sv | 19 +
 rtl/qcl_swpo_bank.sv | 52 +++++
 rtl/qcl_swpo_frame.sv | 111 +++++++++++
 tb/tb_qcl_swpo_frame.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/qcl_pkg.sv
// Shared types for the QCL serial-write / parallel-out frame assembler.
package qcl_pkg;

  typedef enum logic {
    COMMIT_LAST = 1'b0,
    COMMIT_ALL  = 1'b1
  } qcl_commit_mode_e;

  typedef enum logic {
    FILL_FILLING = 1'b0,
    FILL_PENDING = 1'b1
  } qcl_fill_state_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } qcl_out_state_e;

endpackage

// File: rtl/qcl_swpo_bank.sv
// Addressed fill bank with a per-element written mask and an address range check.
// bank_next_o already includes the write of the current cycle so the top level
// can hand a complete frame to the output register in the committing cycle.
module qcl_swpo_bank #(
  parameter int width_p      = 8,
  parameter int addr_width_p = 3,
  parameter int els_p        = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            we_i,
  input  logic                            clear_mask_i,
  input  logic [addr_width_p-1:0]         addr_i,
  input  logic [width_p-1:0]              data_i,
  output logic [els_p-1:0][width_p-1:0]   bank_next_o,
  output logic                            mask_full_o,
  output logic                            in_range_o
);

  logic [els_p-1:0][width_p-1:0] r_bank;
  logic [els_p-1:0]              r_mask;
  logic [els_p-1:0][width_p-1:0] w_bankNext;
  logic [els_p-1:0]              w_maskNext;

  assign in_range_o  = (32'(addr_i) < els_p);
  assign bank_next_o = w_bankNext;
  assign mask_full_o = &w_maskNext;

  // Apply the current write to a copy of the bank and mask; only in-range addresses can match.
  always_comb begin
    w_bankNext = r_bank;
    w_maskNext = r_mask;
    for (int i = 0; i < els_p; i++) begin
      if (we_i && (32'(addr_i) == i)) begin
        w_bankNext[i] = data_i;
        w_maskNext[i] = 1'b1;
      end
    end
  end

  // Register the bank; the mask restarts from empty whenever a frame leaves for the output.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_bank <= '0;
      r_mask <= '0;
    end else begin
      r_bank <= w_bankNext;
      r_mask <= clear_mask_i ? '0 : w_maskNext;
    end
  end

endmodule

// File: rtl/qcl_swpo_frame.sv
// Serial-write / parallel-out frame assembler with double buffering.
// The fill bank collects addressed words; a committed frame is copied into the
// output holding register as soon as the consumer slot is free.
module qcl_swpo_frame
  import qcl_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int addr_width_p  = 3,
  parameter int els_p         = 4,
  parameter int commit_mode_p = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  output logic                            ready_o,
  input  logic [addr_width_p-1:0]         addr_i,
  input  logic [width_p-1:0]              data_i,
  output logic                            v_o,
  output logic [els_p-1:0][width_p-1:0]   data_o,
  input  logic                            yumi_i,
  output logic                            err_o
);

  qcl_fill_state_e r_fillState, w_fillNext;
  qcl_out_state_e  r_outState,  w_outNext;

  logic [els_p-1:0][width_p-1:0] r_dataOut;
  logic [els_p-1:0][width_p-1:0] w_bankNext;
  logic                          r_err;
  logic                          w_fire;
  logic                          w_inRange;
  logic                          w_write;
  logic                          w_maskFull;
  logic                          w_commit;
  logic                          w_outFree;
  logic                          w_transfer;

  assign w_fire     = v_i & ready_o;
  assign w_write    = w_fire & w_inRange;
  assign w_commit   = w_write & ((commit_mode_p == int'(COMMIT_ALL)) ? w_maskFull
                                 : (32'(addr_i) == 32'(els_p - 1)));
  assign w_outFree  = (r_outState == OUT_EMPTY) | yumi_i;
  assign w_transfer = w_outFree & (w_commit | (r_fillState == FILL_PENDING));

  qcl_swpo_bank #(
    .width_p      (width_p),
    .addr_width_p (addr_width_p),
    .els_p        (els_p)
  ) u_bank (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .we_i         (w_write),
    .clear_mask_i (w_transfer),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .bank_next_o  (w_bankNext),
    .mask_full_o  (w_maskFull),
    .in_range_o   (w_inRange)
  );

  // State registers for the fill and output FSMs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fillState <= FILL_FILLING;
      r_outState  <= OUT_EMPTY;
    end else begin
      r_fillState <= w_fillNext;
      r_outState  <= w_outNext;
    end
  end

  // Fill side stalls on a commit that finds the output occupied; output goes valid on any transfer.
  always_comb begin
    w_fillNext = r_fillState;
    w_outNext  = r_outState;
    case (r_fillState)
      FILL_FILLING: if (w_commit && !w_outFree) w_fillNext = FILL_PENDING;
      FILL_PENDING: if (w_outFree)              w_fillNext = FILL_FILLING;
      default:                                  w_fillNext = FILL_FILLING;
    endcase
    if (w_transfer) begin
      w_outNext = OUT_VALID;
    end else if (yumi_i) begin
      w_outNext = OUT_EMPTY;
    end
  end

  // Handshake outputs decoded straight from the FSM states.
  always_comb begin
    ready_o = (r_fillState == FILL_FILLING);
    v_o     = (r_outState == OUT_VALID);
  end

  // Output holding register takes the bank including this cycle's write; err flags an out-of-range fire.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dataOut <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_transfer) r_dataOut <= w_bankNext;
      r_err <= w_fire & ~w_inRange;
    end
  end

  assign data_o = r_dataOut;
  assign err_o  = r_err;

  a_yumiNeedsValid: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));
  a_addrCoversEls:  assert property (@(posedge clk_i) (els_p <= (1 << addr_width_p)) && (els_p >= 2));

endmodule

// File: tb/tb_qcl_swpo_frame.sv
// Bench for qcl_swpo_frame: instance 0 commits on the last address, instance 1
// commits once every element has been written. A frame-level model predicts the
// outputs of both instances each cycle; directed literals pin the key frames.
module tb_qcl_swpo_frame;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  logic            vIn[2];
  logic            yumiIn[2];
  logic [2:0]      addrIn[2];
  logic [7:0]      dataIn[2];
  logic            readyOut[2];
  logic            vOut[2];
  logic            errOut[2];
  logic [3:0][7:0] dataOut[2];

  int checks = 0;
  int errors = 0;

  qcl_swpo_frame #(
    .width_p(8), .addr_width_p(3), .els_p(4), .commit_mode_p(0)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rstN), .v_i(vIn[0]), .ready_o(readyOut[0]),
    .addr_i(addrIn[0]), .data_i(dataIn[0]), .v_o(vOut[0]), .data_o(dataOut[0]),
    .yumi_i(yumiIn[0]), .err_o(errOut[0])
  );

  qcl_swpo_frame #(
    .width_p(8), .addr_width_p(3), .els_p(4), .commit_mode_p(1)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rstN), .v_i(vIn[1]), .ready_o(readyOut[1]),
    .addr_i(addrIn[1]), .data_i(dataIn[1]), .v_o(vOut[1]), .data_o(dataOut[1]),
    .yumi_i(yumiIn[1]), .err_o(errOut[1])
  );

  // Frame-level model: which elements have been written, whether a finished
  // frame is waiting for the consumer, and what the consumer currently holds.
  logic [7:0]      mBank[2][4];
  bit              mWritten[2][4];
  bit              mPending[2];
  bit              mV[2];
  bit              mErr[2];
  logic [3:0][7:0] mOut[2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        mBank[m][i]    = '0;
        mWritten[m][i] = 1'b0;
      end
      mPending[m] = 1'b0;
      mV[m]       = 1'b0;
      mErr[m]     = 1'b0;
      mOut[m]     = '0;
    end
  endtask

  task automatic modelStep(input int m);
    bit fire, frameDone, consumerFree, allSeen;
    int a;
    a         = int'(addrIn[m]);
    fire      = vIn[m] && !mPending[m];
    frameDone = 1'b0;
    mErr[m]   = fire && (a >= 4);
    if (fire && a < 4) begin
      mBank[m][a]    = dataIn[m];
      mWritten[m][a] = 1'b1;
      if (m == 0) begin
        frameDone = (a == 3);
      end else begin
        allSeen = 1'b1;
        for (int i = 0; i < 4; i++) if (!mWritten[m][i]) allSeen = 1'b0;
        frameDone = allSeen;
      end
    end
    consumerFree = !mV[m] || yumiIn[m];
    if ((frameDone || mPending[m]) && consumerFree) begin
      for (int i = 0; i < 4; i++) begin
        mOut[m][i]     = mBank[m][i];
        mWritten[m][i] = 1'b0;
      end
      mV[m]       = 1'b1;
      mPending[m] = 1'b0;
    end else begin
      if (frameDone)  mPending[m] = 1'b1;
      if (yumiIn[m])  mV[m]       = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) modelReset();
    else for (int m = 0; m < 2; m++) modelStep(m);
  end

  // Every cycle out of reset, both instances must match the model.
  always @(negedge clk) begin
    if (rstN) begin
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("m%0d ready", m), 32'(readyOut[m]), 32'(!mPending[m]));
        checkOutput($sformatf("m%0d v", m),     32'(vOut[m]),     32'(mV[m]));
        checkOutput($sformatf("m%0d err", m),   32'(errOut[m]),   32'(mErr[m]));
        checkOutput($sformatf("m%0d data", m),  dataOut[m],       mOut[m]);
      end
    end
  end

  // Drive one instance for one cycle; the other instance idles.
  task automatic applyStimulus(input int m, input logic v, input logic [2:0] addr,
                               input logic [7:0] data, input logic yumi);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vIn[k] = 1'b0; addrIn[k] = '0; dataIn[k] = '0; yumiIn[k] = 1'b0;
    end
    vIn[m] = v; addrIn[m] = addr; dataIn[m] = data; yumiIn[m] = yumi;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      vIn[k] = 1'b0; addrIn[k] = '0; dataIn[k] = '0; yumiIn[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checkOutput("reset ready", 32'(readyOut[m]), 32'd1);
      checkOutput("reset v",     32'(vOut[m]),     32'd0);
      checkOutput("reset err",   32'(errOut[m]),   32'd0);
      checkOutput("reset data",  dataOut[m],       32'h0);
    end
    rstN = 1'b1;

    // Commit on last address.
    applyStimulus(0, 1, 0, 8'd11, 0);
    applyStimulus(0, 1, 1, 8'd22, 0);
    applyStimulus(0, 1, 2, 8'd33, 0);
    applyStimulus(0, 1, 3, 8'd44, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("f1 v",    32'(vOut[0]), 32'd1);
    checkOutput("f1 data", dataOut[0],   32'h2C21160B);

    // Second frame while the first is still held: fill side stalls.
    applyStimulus(0, 1, 0, 8'd55, 0);
    applyStimulus(0, 1, 1, 8'd66, 0);
    applyStimulus(0, 1, 2, 8'd77, 0);
    applyStimulus(0, 1, 3, 8'd88, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("f2 stall ready", 32'(readyOut[0]), 32'd0);
    checkOutput("f2 held data",   dataOut[0],       32'h2C21160B);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("f2 v",     32'(vOut[0]),     32'd1);
    checkOutput("f2 ready", 32'(readyOut[0]), 32'd1);
    checkOutput("f2 data",  dataOut[0],       32'h584D4237);

    // Out-of-range write after draining the output.
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 6, 8'hAA, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("oor err", 32'(errOut[0]), 32'd1);
    checkOutput("oor v",   32'(vOut[0]),   32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("oor err pulse", 32'(errOut[0]), 32'd0);
    // Only addr 3 written: elements 0..2 carry over from frame 2.
    applyStimulus(0, 1, 3, 8'h99, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("carry v",    32'(vOut[0]), 32'd1);
    checkOutput("carry data", dataOut[0],   32'h994D4237);

    // Commit only when every element is seen; rewriting addr 0 does not complete it.
    applyStimulus(1, 1, 2, 8'd5, 0);
    applyStimulus(1, 1, 0, 8'd6, 0);
    applyStimulus(1, 1, 3, 8'd7, 0);
    applyStimulus(1, 1, 0, 8'd8, 0);
    applyStimulus(1, 1, 1, 8'd9, 0);
    checkOutput("all no commit v", 32'(vOut[1]), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("all v",    32'(vOut[1]), 32'd1);
    checkOutput("all data", dataOut[1],   32'h07050908);

    // Commit coincides with yumi: no bubble.
    applyStimulus(1, 1, 0, 8'd1, 0);
    applyStimulus(1, 1, 1, 8'd2, 0);
    applyStimulus(1, 1, 2, 8'd3, 0);
    applyStimulus(1, 1, 3, 8'd4, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b2b v",    32'(vOut[1]), 32'd1);
    checkOutput("b2b data", dataOut[1],   32'h04030201);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("drain v",    32'(vOut[1]), 32'd0);
    checkOutput("drain data", dataOut[1],   32'h04030201);

    // Reset in the middle of partially written frames.
    applyStimulus(0, 1, 0, 8'd1, 0);
    applyStimulus(0, 1, 1, 8'd2, 0);
    applyStimulus(1, 1, 0, 8'hB1, 0);
    applyStimulus(1, 1, 1, 8'hB2, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid reset v",     32'(vOut[0]),     32'd0);
    checkOutput("mid reset data",  dataOut[0],       32'h0);
    checkOutput("mid reset ready", 32'(readyOut[0]), 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, 1, 3, 8'h12, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post reset data", dataOut[0], 32'h12000000);
    applyStimulus(1, 1, 2, 8'hA3, 0);
    applyStimulus(1, 1, 3, 8'hA4, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("post reset mask empty", 32'(vOut[1]), 32'd0);
    applyStimulus(1, 1, 0, 8'hA1, 0);
    applyStimulus(1, 1, 1, 8'hA2, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("post reset all v",    32'(vOut[1]), 32'd1);
    checkOutput("post reset all data", dataOut[1],   32'hA4A3A2A1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
